// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - op and state encodings shared by the HI/LO multiply/divide unit
package md_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_t;

  // Ops that finish in the issue cycle without leaving IDLE.
  function automatic logic is_move_op(input md_op_t op);
    return (op == OP_MTHI) || (op == OP_MTLO) || (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// rtl/md_div_iter.sv - restoring divider, one quotient bit per cycle, with sign fix-up
import md_unit_pkg::*;

module md_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH);

  logic             run_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q, raw_q;
  logic             neg_quo_q, neg_rem_q, zero_q;

  logic [WIDTH-1:0] dvd_abs, dsr_abs;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d, quo_d;

  // Operand magnitudes at start, and one restoring step on the running state.
  always_comb begin
    dvd_abs = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    dsr_abs = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
    trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Iteration state: load on start, shift one bit per cycle until the count runs out.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      raw_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
    end else if (abort_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q     <= 1'b1;
      cnt_q     <= CW'(WIDTH - 1);
      rem_q     <= '0;
      quo_q     <= dvd_abs;
      dsr_q     <= dsr_abs;
      raw_q     <= dividend_i;
      zero_q    <= (divisor_i == '0);
      neg_quo_q <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
      neg_rem_q <= signed_i && dividend_i[WIDTH-1];
    end else if (run_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

  // Final iteration flag and sign-corrected results; divide by zero returns all ones / raw dividend.
  always_comb begin
    done_o      = run_q && (cnt_q == '0);
    quotient_o  = zero_q ? '1    : (neg_quo_q ? -quo_q : quo_q);
    remainder_o = zero_q ? raw_q : (neg_rem_q ? -rem_q : rem_q);
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - HI/LO multiply/divide unit; MD_EARLY_OUT_EN enables trivial-operand early completion
import md_unit_pkg::*;

module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             req_ack,
  input  logic             wr_disable,
  input  logic             flush,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MCW = $clog2(MUL_LAT) + 1;

  md_op_t           op;
  md_state_t        state_q;
  logic [MCW-1:0]   mcnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, opa_q, opb_q;
  logic             mul_sgn_q;

  logic               idle_req, mul_early, div_early, div_start, div_last;
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;
  logic [WIDTH-1:0]   div_quo, div_rem;

  assign op = md_op_t'(req_op);

`ifdef MD_EARLY_OUT_EN
  logic [WIDTH-1:0] mag1, mag2;
`endif

  // Issue decode, early-out detection and the multiplier datapath.
  always_comb begin
    idle_req  = (state_q == ST_IDLE) && req_valid && !flush;
    mul_early = 1'b0;
    div_early = 1'b0;
`ifdef MD_EARLY_OUT_EN
    mag1      = (op == OP_DIV && src1[WIDTH-1]) ? -src1 : src1;
    mag2      = (op == OP_DIV && src2[WIDTH-1]) ? -src2 : src2;
    mul_early = (src1 == '0) || (src2 == '0);
    div_early = (src2 != '0) && (mag1 < mag2);
`endif
    div_start = idle_req && ((op == OP_DIV) || (op == OP_DIVU)) && !div_early;
    mul_a_ext = {{WIDTH{mul_sgn_q & opa_q[WIDTH-1]}}, opa_q};
    mul_b_ext = {{WIDTH{mul_sgn_q & opb_q[WIDTH-1]}}, opb_q};
    product   = mul_a_ext * mul_b_ext;
  end

  md_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .reset       (reset),
    .abort_i     (flush),
    .start_i     (div_start),
    .signed_i    (op == OP_DIV),
    .dividend_i  (src1),
    .divisor_i   (src2),
    .done_o      (div_last),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Control FSM and HI/LO registers; flush wins over any write or completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mcnt_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      mul_sgn_q <= 1'b0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      mcnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            case (op)
              OP_MTHI: if (!wr_disable) hi_q <= src1;
              OP_MTLO: if (!wr_disable) lo_q <= src1;
              OP_MULT, OP_MULTU: begin
                if (mul_early) begin
                  if (!wr_disable) begin
                    hi_q <= '0;
                    lo_q <= '0;
                  end
                  state_q <= ST_DONE;
                end else begin
                  opa_q     <= src1;
                  opb_q     <= src2;
                  mul_sgn_q <= (op == OP_MULT);
                  mcnt_q    <= MCW'(MUL_LAT - 1);
                  state_q   <= ST_MUL;
                end
              end
              OP_DIV, OP_DIVU: begin
                if (div_early) begin
                  if (!wr_disable) begin
                    hi_q <= src1;
                    lo_q <= '0;
                  end
                  state_q <= ST_DONE;
                end else begin
                  state_q <= ST_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (mcnt_q == '0) begin
            if (!wr_disable) begin
              hi_q <= product[2*WIDTH-1:WIDTH];
              lo_q <= product[WIDTH-1:0];
            end
            state_q <= ST_DONE;
          end else begin
            mcnt_q <= mcnt_q - 1'b1;
          end
        end
        ST_DIV: if (div_last) state_q <= ST_FIX;
        ST_FIX: begin
          if (!wr_disable) begin
            hi_q <= div_rem;
            lo_q <= div_quo;
          end
          state_q <= ST_DONE;
        end
        ST_DONE: if (req_ack) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Completion and move-from data; moves answer combinationally in the issue cycle.
  always_comb begin
    result_valid = (state_q == ST_DONE) || (idle_req && is_move_op(op));
    result       = '0;
    if (idle_req && op == OP_MFHI) result = hi_q;
    if (idle_req && op == OP_MFLO) result = lo_q;
    busy = (state_q != ST_IDLE);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit
import md_unit_pkg::*;

module tb_md_unit;

  localparam int W  = 32;
  localparam int ML = 2;

  logic         clk = 1'b0;
  logic         reset, req_valid, req_ack, wr_disable, flush;
  logic [3:0]   req_op;
  logic [W-1:0] src1, src2;
  logic         result_valid, busy;
  logic [W-1:0] result, hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .src1         (src1),
    .src2         (src2),
    .req_ack      (req_ack),
    .wr_disable   (wr_disable),
    .flush        (flush),
    .result_valid (result_valid),
    .result       (result),
    .busy         (busy),
    .hi           (hi),
    .lo           (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Negedges from driving a request until result_valid is seen (0 = same cycle).
  function automatic int exp_wait(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
`ifdef MD_EARLY_OUT_EN
    logic [31:0] aa, bb;
    aa = (op == OP_DIV && a[31]) ? -a : a;
    bb = (op == OP_DIV && b[31]) ? -b : b;
    if ((op == OP_MULT || op == OP_MULTU) && (a == 0 || b == 0)) return 1;
    if ((op == OP_DIV || op == OP_DIVU) && b != 0 && aa < bb) return 1;
`endif
    case (op)
      OP_MULT, OP_MULTU: return ML + 1;
      OP_DIV, OP_DIVU:   return W + 2;
      default:           return 0;
    endcase
  endfunction

  task automatic model(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic [31:0] r);
    logic [63:0] p;
    h = m_hi; l = m_lo; r = '0;
    case (op)
      OP_MULT: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        h = p[63:32]; l = p[31:0];
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32]; l = p[31:0];
      end
      OP_DIV: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = $signed(a) / $signed(b); h = $signed(a) % $signed(b); end
      end
      OP_DIVU: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input string tag, input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic wd, input logic wd_late,
                        input logic [31:0] e_hi, input logic [31:0] e_lo, input logic [31:0] e_res,
                        input int hold);
    exp_t e, g;
    int   n, w;
    e.hi = e_hi; e.lo = e_lo; e.res = e_res;
    sb_q.push_back(e);
    w = exp_wait(op, a, b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; src1 = a; src2 = b; wr_disable = wd; req_ack = 1'b0;
    n = 0;
    #1;
    while (!result_valid && n < 200) begin
      if (n == w - 1) wr_disable = wd_late;
      @(negedge clk);
      n++;
      #1;
    end
    if (!result_valid) check_eq({tag, "_timeout"}, result_valid, 1);
    check_eq({tag, "_lat"}, n, w);
    g = sb_q.pop_front();
    check_eq({tag, "_res"}, result, g.res);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      #1;
      check_eq({tag, "_hold_rv"}, result_valid, 1);
      check_eq({tag, "_hold_busy"}, busy, 1);
      check_eq({tag, "_hold_lo"}, lo, g.lo);
    end
    req_ack = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_ack = 1'b0; wr_disable = 1'b0; req_op = OP_NONE;
    #1;
    check_eq({tag, "_hi"}, hi, g.hi);
    check_eq({tag, "_lo"}, lo, g.lo);
    check_eq({tag, "_idle"}, busy, 0);
    m_hi = g.hi; m_lo = g.lo;
  endtask

  // A request may only drop while busy under flush or reset.
  always begin
    @(negedge clk);
    #1;
    if (busy && !flush && !reset) check_eq("req_held", req_valid, 1);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = OP_NONE; src1 = '0; src2 = '0;
    req_ack = 1'b0; wr_disable = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rv", result_valid, 0);
    check_eq("rst_res", result, 0);

    run_op("mult", OP_MULT, 32'hFFFFFFFE, 32'd3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0);
    run_op("multu", OP_MULTU, 32'hFFFFFFFE, 32'd3, 0, 0, 32'h00000002, 32'hFFFFFFFA, 0, 0);
    run_op("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 0, 0);
    run_op("div0", OP_DIV, 32'h12345678, 32'd0, 0, 0, 32'h12345678, 32'hFFFFFFFF, 0, 0);
    run_op("mflo", OP_MFLO, 0, 0, 0, 0, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("mfhi", OP_MFHI, 0, 0, 0, 0, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 0);
    run_op("divu_small", OP_DIVU, 32'd5, 32'd9, 0, 0, 32'd5, 32'd0, 0, 0);
    run_op("mult_zero", OP_MULT, 32'd0, 32'd77, 0, 0, 32'd0, 32'd0, 0, 0);

    // Flush ten cycles into a divide.
    run_op("mtlo_seed", OP_MTLO, 32'h0BADF00D, 0, 0, 0, m_hi, 32'h0BADF00D, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIV; src1 = 32'd1000; src2 = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0; req_op = OP_NONE;
    #1;
    check_eq("flush_busy", busy, 0);
    check_eq("flush_rv", result_valid, 0);
    check_eq("flush_hi", hi, m_hi);
    check_eq("flush_lo", lo, m_lo);
    run_op("mult_after_flush", OP_MULT, 32'd7, 32'd6, 0, 0, 32'd0, 32'd42, 0, 0);

    // Completion-time write suppression, then held in DONE without ack.
    run_op("mult_wd", OP_MULT, 32'h00010000, 32'h00010000, 0, 1, m_hi, m_lo, 0, 3);

    run_op("mthi_wd", OP_MTHI, 32'hA5A5A5A5, 0, 1, 1, m_hi, m_lo, 0, 0);
    run_op("mthi", OP_MTHI, 32'hA5A5A5A5, 0, 0, 0, 32'hA5A5A5A5, m_lo, 0, 0);

    // Flush beats an MT write in the same IDLE cycle.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MTLO; src1 = 32'hDEAD0000; flush = 1'b1;
    #1;
    check_eq("mt_flush_rv", result_valid, 0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0; req_op = OP_NONE;
    #1;
    check_eq("mt_flush_lo", lo, m_lo);

    for (int i = 0; i < 8; i++) begin
      md_op_t      rop;
      logic [31:0] a, b, h, l, r;
      case ($urandom_range(0, 3))
        0:       rop = OP_MULT;
        1:       rop = OP_MULTU;
        2:       rop = OP_DIV;
        default: rop = OP_DIVU;
      endcase
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (rop == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      model(rop, a, b, h, l, r);
      run_op("rnd", rop, a, b, 0, 0, h, l, r, 0);
    end

    // Reset in the middle of a divide.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIVU; src1 = 32'd999; src2 = 32'd4;
    repeat (5) @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; req_op = OP_NONE;
    #1;
    check_eq("rst_div_busy", busy, 0);
    check_eq("rst_div_hi", hi, 0);
    check_eq("rst_div_lo", lo, 0);
    m_hi = '0; m_lo = '0;
    run_op("divu_after_rst", OP_DIVU, 32'd999, 32'd4, 0, 0, 32'd3, 32'd249, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
